// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer (setup/pulse/hold/busy-wait); LCD_CTRL_INIT_SEQ_EN adds power-up delay and init bytes
module lcd_ctrl #(
  parameter int T_SETUP    = 2,
  parameter int T_EN_HIGH  = 12,
  parameter int T_HOLD     = 2,
  parameter int T_CMD_WAIT = 2000,
  parameter int T_CLR_WAIT = 80000,
  parameter int T_PWRUP    = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_data
);
  function automatic int at_least_one(input int v);
    return v < 1 ? 1 : v;
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int MAXP = max2(max2(max2(T_SETUP, T_EN_HIGH), max2(T_HOLD, T_CMD_WAIT)), max2(T_CLR_WAIT, T_PWRUP));
  localparam int CW = $clog2(at_least_one(MAXP)) + 1;
  localparam logic [CW-1:0] L_SETUP = CW'(at_least_one(T_SETUP) - 1);
  localparam logic [CW-1:0] L_EN    = CW'(at_least_one(T_EN_HIGH) - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(at_least_one(T_HOLD) - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(at_least_one(T_CMD_WAIT) - 1);
  localparam logic [CW-1:0] L_CLR   = CW'(at_least_one(T_CLR_WAIT) - 1);
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
`ifdef LCD_CTRL_INIT_SEQ_EN
  localparam logic [CW-1:0] L_PWRUP = CW'(at_least_one(T_PWRUP) - 1);
  localparam state_t RST_STATE = PWRUP;
  logic [1:0] idx, idx_n;
  logic [7:0] init_byte;
  assign init_byte = idx == 2'd0 ? 8'h38 : idx == 2'd1 ? 8'h0C : idx == 2'd2 ? 8'h01 : 8'h06;
`else
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic done, clr, rs_n, en_n, ready_n, init_done_n;
  logic [7:0] data_n;
  assign done = cnt == '0;
  assign clr = !o_lcd_rs && o_lcd_data[7:2] == 6'd0 && o_lcd_data[1:0] != 2'd0;
  assign o_lcd_rw = 1'b0;
  // Next state, counter reload and next pin values; every output is registered from these
  always_comb begin
    state_n = state;
    cnt_n = done ? '0 : cnt - CW'(1);
    rs_n = o_lcd_rs;
    data_n = o_lcd_data;
    en_n = 1'b0;
`ifdef LCD_CTRL_INIT_SEQ_EN
    init_done_n = o_init_done;
    idx_n = idx;
`else
    init_done_n = 1'b1;
`endif
    unique case (state)
`ifdef LCD_CTRL_INIT_SEQ_EN
      PWRUP: if (!o_lcd_on) cnt_n = L_PWRUP;
             else if (done) state_n = INIT;
      INIT: begin
        rs_n = 1'b0;
        data_n = init_byte;
        state_n = SETUP;
        cnt_n = L_SETUP;
      end
`endif
      IDLE: if (i_valid && o_ready) begin
        rs_n = i_rs;
        data_n = i_data;
        state_n = SETUP;
        cnt_n = L_SETUP;
      end
      SETUP: if (done) begin
        en_n = 1'b1;
        state_n = PULSE;
        cnt_n = L_EN;
      end
      PULSE: begin
        en_n = !done;
        if (done) begin
          state_n = HOLD;
          cnt_n = L_HOLD;
        end
      end
      HOLD: if (done) begin
        state_n = WAIT;
        cnt_n = clr ? L_CLR : L_CMD;
      end
      WAIT: if (done) begin
`ifdef LCD_CTRL_INIT_SEQ_EN
        if (o_init_done) state_n = IDLE;
        else if (idx == 2'd3) begin
          state_n = IDLE;
          init_done_n = 1'b1;
        end else begin
          state_n = INIT;
          idx_n = idx + 2'd1;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = RST_STATE;
    endcase
    ready_n = state_n == IDLE && init_done_n;
  end
  // State, counter and output registers; reset aborts any transfer in flight
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= RST_STATE;
      cnt <= '0;
      o_lcd_rs <= 1'b0;
      o_lcd_data <= 8'h00;
      o_lcd_en <= 1'b0;
      o_ready <= 1'b0;
      o_init_done <= 1'b0;
      o_lcd_on <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_lcd_rs <= rs_n;
      o_lcd_data <= data_n;
      o_lcd_en <= en_n;
      o_ready <= ready_n;
      o_init_done <= init_done_n;
      o_lcd_on <= 1'b1;
    end
`ifdef LCD_CTRL_INIT_SEQ_EN
  // Init byte index, advanced after each init byte's busy-wait
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) idx <= 2'd0;
    else idx <= idx_n;
`endif
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: randomized transfers checked cycle-by-cycle against phase-duration model
module tb_lcd_ctrl;
  localparam int TS = 2, TE = 3, TH = 2, TCMD = 5, TCLR = 9, TPW = 4;
  logic i_clk = 1'b0, i_rst = 1'b0, i_valid = 1'b0, i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic o_ready, o_init_done, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [7:0] o_lcd_data;
  int n_checks = 0, n_pass = 0;
  logic last_rs = 1'b0;
  logic [7:0] last_d = 8'h00;
  lcd_ctrl #(.T_SETUP(TS), .T_EN_HIGH(TE), .T_HOLD(TH), .T_CMD_WAIT(TCMD), .T_CLR_WAIT(TCLR), .T_PWRUP(TPW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_rs(i_rs), .i_data(i_data),
    .o_ready(o_ready), .o_init_done(o_init_done), .o_lcd_on(o_lcd_on), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_data(o_lcd_data)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic pins(input logic en, input logic rdy);
    check("en", 32'(o_lcd_en), 32'(en));
    check("rs", 32'(o_lcd_rs), 32'(last_rs));
    check("data", 32'(o_lcd_data), 32'(last_d));
    check("ready", 32'(o_ready), 32'(rdy));
    check("rw", 32'(o_lcd_rw), 32'd0);
    check("on", 32'(o_lcd_on), 32'd1);
    check("init_done", 32'(o_init_done), 32'd1);
  endtask
  task automatic after_reset();
`ifdef LCD_CTRL_INIT_SEQ_EN
    logic [7:0] seen[$];
    logic prev_en = 1'b0;
    int cyc = 0;
    logic [7:0] exp_b[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    while (cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
      check("init_on", 32'(o_lcd_on), 32'd1);
      check("init_rw", 32'(o_lcd_rw), 32'd0);
      check("ready_vs_done", 32'(o_ready), 32'(o_init_done));
      if (o_lcd_en && !prev_en) begin
        seen.push_back(o_lcd_data);
        check("init_rs", 32'(o_lcd_rs), 32'd0);
      end
      prev_en = o_lcd_en;
      if (o_ready) break;
    end
    check("init_reached_ready", 32'(o_ready), 32'd1);
    check("init_pulses", 32'(seen.size()), 32'd4);
    for (int j = 0; j < 4 && j < seen.size(); j++) check("init_byte", 32'(seen[j]), 32'(exp_b[j]));
    last_rs = 1'b0;
    last_d = 8'h06;
`else
    last_rs = 1'b0;
    last_d = 8'h00;
    @(negedge i_clk);
    pins(1'b0, 1'b1);
`endif
  endtask
  task automatic xfer(input logic rs, input logic [7:0] d, input bit pert, input logic [7:0] pd);
    int w, len;
    check("hs_ready", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_rs = rs;
    i_data = d;
    w = (!rs && d >= 8'd1 && d <= 8'd3) ? TCLR : TCMD;
    len = TS + TE + TH + w + 1;
    last_rs = rs;
    last_d = d;
    for (int k = 1; k <= len; k++) begin
      @(negedge i_clk);
      pins(k > TS && k <= TS + TE, k == len);
      if (pert && k < len) begin
        i_data = pd;
        i_rs = 1'($urandom_range(0, 1));
      end else if (!pert && k == 1) i_valid = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(negedge i_clk);
      pins(1'b0, 1'b1);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    #1 i_rst = 1'b1;
    #11;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_done", 32'(o_init_done), 32'd0);
    check("rst_on", 32'(o_lcd_on), 32'd0);
    check("rst_en", 32'(o_lcd_en), 32'd0);
    check("rst_data", 32'(o_lcd_data), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    after_reset();
    xfer(1'b1, 8'h41, 1'b0, 8'h00);
    idle(2);
    xfer(1'b0, 8'h01, 1'b0, 8'h00);
    xfer(1'b0, 8'h80, 1'b0, 8'h00);
    xfer(1'b1, 8'h01, 1'b0, 8'h00);
    xfer(1'b0, 8'h02, 1'b0, 8'h00);
    xfer(1'b0, 8'h03, 1'b0, 8'h00);
    xfer(1'b0, 8'h04, 1'b0, 8'h00);
    xfer(1'b1, 8'h41, 1'b1, 8'h42);
    check("next_data_held", 32'(i_data), 32'h42);
    i_rs = 1'b1;
    xfer(1'b1, 8'h42, 1'b0, 8'h00);
    idle(1);
    i_valid = 1'b1;
    i_rs = 1'b1;
    i_data = 8'h55;
    for (int k = 1; k <= TS + 2; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
    end
    check("pulse_en", 32'(o_lcd_en), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("arst_en", 32'(o_lcd_en), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd0);
    check("arst_data", 32'(o_lcd_data), 32'd0);
    check("arst_rs", 32'(o_lcd_rs), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    after_reset();
    xfer(1'b1, 8'h5A, 1'b0, 8'h00);
    for (int n = 0; n < 25; n++) begin
      logic rs;
      logic [7:0] d;
      rs = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 2) == 0 ? 8'($urandom_range(0, 3)) : 8'($urandom);
      xfer(rs, d, $urandom_range(0, 3) == 0, 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
